nand_struct_cell: RTL and testbench

//   Structural 2-input NAND array built from gate-level primitives (one nand2 per bit).

---
 rtl/nand_struct_cell_pkg.sv | 15 +
 rtl/nand_struct_cell_if.sv | 17 +
 rtl/nand_struct_cell_nand2_bit.sv | 8 +
 rtl/nand_struct_cell.sv | 56 +++++
 tb/tb_nand_struct_cell.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/nand_struct_cell_pkg.sv
// Shared constants and helpers for the structural NAND cell.
package nand_struct_pkg;
    localparam int NAND_DEF_WIDTH   = 1;
    localparam int NAND_MAX_WIDTH   = 1024;
    localparam int NAND_CHG_PULSE_CYCLES = 1;

    // All-ones of the requested width; matches NAND(0,0) on every bit.
    function automatic logic [NAND_MAX_WIDTH-1:0] nand_rst_val(input int width);
        logic [NAND_MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NAND_MAX_WIDTH; i++)
            if (i < width) v[i] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/nand_struct_cell_if.sv
// Operand/result bundle for nand_struct_cell; err exists only with NAND_STRUCT_CHECK_EN.
interface nand_struct_cell_if #(parameter int WIDTH = nand_struct_pkg::NAND_DEF_WIDTH);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_chg;
`ifdef NAND_STRUCT_CHECK_EN
    logic             err;

    modport master (output a, b, input o, o_q, o_chg, err);
    modport slave  (input a, b, output o, o_q, o_chg, err);
`else
    modport master (output a, b, input o, o_q, o_chg);
    modport slave  (input a, b, output o, o_q, o_chg);
`endif
endinterface

// File: rtl/nand_struct_cell_nand2_bit.sv
// Single-bit leaf: one primitive nand gate so X/Z follow gate semantics.
module nand2_bit (
    input  wire a,
    input  wire b,
    output wire y
);
    nand g_nand (y, a, b);
endmodule

// File: rtl/nand_struct_cell.sv
// Bitwise structural NAND with registered copy and per-bit toggle pulse.
// Optional sticky self-check output err when NAND_STRUCT_CHECK_EN is defined.
module nand_struct_cell
    import nand_struct_pkg::*;
#(
    parameter int               WIDTH   = NAND_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(nand_rst_val(WIDTH))
) (
    input logic               clk,
    input logic               rst,
    nand_struct_cell_if.slave bus
);
    logic [WIDTH-1:0] o_w;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] chg_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand2_bit u_nand (.a(bus.a[i]), .b(bus.b[i]), .y(o_w[i]));
    end

    // chg compares the incoming value with the one being replaced, so it
    // lines up with the cycle in which o_q shows the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= RST_VAL;
            chg_r <= '0;
        end else begin
            q_r   <= o_w;
            chg_r <= o_w ^ q_r;
        end
    end

    assign bus.o     = o_w;
    assign bus.o_q   = q_r;
    assign bus.o_chg = chg_r;

`ifdef NAND_STRUCT_CHECK_EN
    logic             err_r;
    logic [WIDTH-1:0] ref_o;
    logic             mismatch;

    // Only judge the gates when inputs are clean 0/1; X/Z propagation is legal.
    assign ref_o    = ~(bus.a & bus.b);
    assign mismatch = !$isunknown({bus.a, bus.b}) && (o_w !== ref_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           err_r <= 1'b0;
        else if (mismatch) err_r <= 1'b1;
    end

    assign bus.err = err_r;

    a_first_mismatch: assert property (@(posedge clk) disable iff (rst) !(mismatch && !err_r))
        else $error("nand_struct_cell: primitive output disagrees with behavioural NAND");
`endif
endmodule

// File: tb/tb_nand_struct_cell.sv
// Directed + random bench for nand_struct_cell at WIDTH=1 and WIDTH=4.
module tb_nand_struct_cell;
    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    nand_struct_cell_if #(.WIDTH(1)) b1 ();
    nand_struct_cell_if #(.WIDTH(4)) b4 ();

    nand_struct_cell #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    nand_struct_cell #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    // Reference state: last captured NAND value and last toggle mask.
    logic [3:0] m_q4, m_c4;
    logic       m_q1, m_c1;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nand4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (x[i] == 1'b1 && y[i] == 1'b1) ? 1'b0 : 1'b1;
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_o1"},   {3'b0, b1.o},     {3'b0, ~(b1.a & b1.b)});
        chk({tag, "_q1"},   {3'b0, b1.o_q},   {3'b0, m_q1});
        chk({tag, "_chg1"}, {3'b0, b1.o_chg}, {3'b0, m_c1});
        chk({tag, "_o4"},   b4.o,     nand4(b4.a, b4.b));
        chk({tag, "_q4"},   b4.o_q,   m_q4);
        chk({tag, "_chg4"}, b4.o_chg, m_c4);
    endtask

    // One rising edge: advance the model from the inputs seen at the edge, then check.
    task automatic step(input string tag);
        logic [3:0] n4;
        logic       n1;
        @(posedge clk);
        if (rst) begin
            m_q4 = 4'hF; m_c4 = 4'h0; m_q1 = 1'b1; m_c1 = 1'b0;
        end else begin
            n4 = nand4(b4.a, b4.b);
            n1 = !(b1.a && b1.b);
            m_c4 = (n4 != m_q4) ? (n4 ^ m_q4) : 4'h0;
            m_c1 = (n1 != m_q1);
            m_q4 = n4;
            m_q1 = n1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0] exp_t1 [4];
        logic [1:0] pat_t1 [4];
        exp_t1 = '{2'b01, 2'b01, 2'b01, 2'b00};
        pat_t1 = '{2'b00, 2'b10, 2'b01, 2'b11};

        rst = 1'b1;
        b1.a = 1'b0; b1.b = 1'b0; b4.a = 4'h0; b4.b = 4'h0;
        m_q4 = 4'hF; m_c4 = 4'h0; m_q1 = 1'b1; m_c1 = 1'b0;
        #2;
        check_all("reset");

        // Truth table on the single-gate instance, 10 time units apart.
        for (int i = 0; i < 4; i++) begin
            {b1.a, b1.b} = pat_t1[i];
            #1;
            chk("tt_o1", {3'b0, b1.o}, {2'b0, exp_t1[i]});
            #9;
        end

        // a=b=1 under reset: o=0 while registers stay at reset values.
        b1.a = 1'b1; b1.b = 1'b1; b4.a = 4'hF; b4.b = 4'hF;
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        step("rel1");
        chk("rel1_chg1_is1", {3'b0, b1.o_chg}, 4'h1);
        step("rel2");
        chk("rel2_chg1_is0", {3'b0, b1.o_chg}, 4'h0);

        // WIDTH=4 pattern: 1100 nand 1010 = 0111.
        @(negedge clk);
        b4.a = 4'b1100; b4.b = 4'b1010;
        #1;
        chk("w4_o", b4.o, 4'b0111);
        step("w4_q");
        chk("w4_q_const", b4.o_q, 4'b0111);

        // Toggle a every cycle with b=1: o_chg stays high continuously.
        b1.b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b1.a = ~b1.a;
            step("tog");
            chk("tog_chg1", {3'b0, b1.o_chg}, 4'h1);
        end

        // Exhaustive 2-bit sweep, then random vectors.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {b1.a, b1.b} = 2'(i);
            b4.a = {4{i[1]}}; b4.b = {4{i[0]}};
            step("sweep");
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            b1.a = 1'($urandom); b1.b = 1'($urandom);
            b4.a = 4'($urandom); b4.b = 4'($urandom);
            #1;
            check_all("rnd_comb");
            step("rnd");
        end

        // Async reset between edges while o_q=0.
        @(negedge clk);
        b1.a = 1'b1; b1.b = 1'b1; b4.a = 4'hF; b4.b = 4'hF;
        step("pre_async");
        #2;
        rst = 1'b1;
        #1;
        m_q4 = 4'hF; m_c4 = 4'h0; m_q1 = 1'b1; m_c1 = 1'b0;
        check_all("async_rst");
        chk("async_o1_live", {3'b0, b1.o}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        step("post_async");

`ifdef NAND_STRUCT_CHECK_EN
        chk("err1", {3'b0, b1.err}, 4'h0);
        chk("err4", {3'b0, b4.err}, 4'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
